// File: rtl/cr_prefix_fe_blk_ctlr.sv
// Prefix front-end block controller: splits framed beats into NUM_BLK blocks of BLK_WORDS beats.
// Optional perf counters (frm_cnt, flush_cnt) are enabled with `define CR_PREFIX_FE_PERF_CTR_EN.
module cr_prefix_fe_blk_ctlr #(
  parameter int DATA_W    = 64,
  parameter int BLK_WORDS = 128,
  parameter int NUM_BLK   = 4,
  localparam int SEL_W    = $clog2(NUM_BLK)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_vbytes,
  input  logic                in_eot,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_vbytes,
  output logic                out_valid,
  output logic [SEL_W-1:0]    blk_sel,
  output logic [NUM_BLK-1:0]  blk_wr,
  output logic                eodb,
  output logic                flush_active,
  output logic                ovfl
`ifdef CR_PREFIX_FE_PERF_CTR_EN
  ,
  output logic [31:0]         frm_cnt,
  output logic [31:0]         flush_cnt
`endif
);

  localparam int WC_W = $clog2(BLK_WORDS) + 1;
  localparam int VB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, DATA, SW_BLK, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [WC_W-1:0]     wc_q, wc_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                eot_q, eot_d;
  logic                rdy_q, rdy_d;
  logic                ov_q, ov_d;
  logic                eodb_q, eodb_d;
  logic [NUM_BLK-1:0]  wr_q, wr_d;
  logic                fa_q, fa_d;
  logic                ovfl_q, ovfl_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [VB_W-1:0]     vb_q, vb_d;
  logic                accept, closing;

  assign accept  = in_valid & rdy_q;
  assign closing = in_eot | (wc_q == WC_W'(BLK_WORDS - 1));

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    sel_d   = sel_q;
    eot_d   = eot_q;
    ov_d    = 1'b0;
    eodb_d  = 1'b0;
    wr_d    = '0;
    ovfl_d  = 1'b0;
    data_d  = data_q;
    vb_d    = vb_q;
    case (state_q)
      IDLE, DATA: begin
        if (accept) begin
          wc_d   = wc_q + WC_W'(1);
          data_d = in_data;
          vb_d   = in_vbytes;
          ov_d   = 1'b1;
          if (closing) begin
            eodb_d  = 1'b1;
            eot_d   = in_eot;
            state_d = SW_BLK;
          end else begin
            state_d = DATA;
          end
        end
      end
      SW_BLK: begin
        wc_d = '0;
        // eot commits every block from the current one upward; otherwise only the current block
        for (int unsigned k = 0; k < NUM_BLK; k++) begin
          wr_d[k] = eot_q ? (SEL_W'(k) >= sel_q) : (SEL_W'(k) == sel_q);
        end
        if (eot_q) begin
          sel_d   = '0;
          state_d = IDLE;
        end else if (sel_q == SEL_W'(NUM_BLK - 1)) begin
          sel_d   = '0;
          state_d = FLUSH;
        end else begin
          sel_d   = sel_q + SEL_W'(1);
          state_d = DATA;
        end
      end
      FLUSH: begin
        if (accept && in_eot) begin
          ovfl_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d != SW_BLK);
    fa_d  = (state_d == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wc_q    <= '0;
      sel_q   <= '0;
      eot_q   <= 1'b0;
      rdy_q   <= 1'b0;
      ov_q    <= 1'b0;
      eodb_q  <= 1'b0;
      wr_q    <= '0;
      fa_q    <= 1'b0;
      ovfl_q  <= 1'b0;
      data_q  <= '0;
      vb_q    <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      sel_q   <= sel_d;
      eot_q   <= eot_d;
      rdy_q   <= rdy_d;
      ov_q    <= ov_d;
      eodb_q  <= eodb_d;
      wr_q    <= wr_d;
      fa_q    <= fa_d;
      ovfl_q  <= ovfl_d;
      data_q  <= data_d;
      vb_q    <= vb_d;
    end
  end

  assign in_ready     = rdy_q;
  assign out_data     = data_q;
  assign out_vbytes   = vb_q;
  assign out_valid    = ov_q;
  assign blk_sel      = sel_q;
  assign blk_wr       = wr_q;
  assign eodb         = eodb_q;
  assign flush_active = fa_q;
  assign ovfl         = ovfl_q;

`ifdef CR_PREFIX_FE_PERF_CTR_EN
  logic [31:0] frm_cnt_q, frm_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    frm_cnt_d   = frm_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == SW_BLK) && eot_q && (frm_cnt_q != '1)) frm_cnt_d = frm_cnt_q + 32'd1;
    if (ovfl_d && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frm_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      frm_cnt_q   <= frm_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign frm_cnt   = frm_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_cr_prefix_fe_blk_ctlr.sv
// Directed bench for cr_prefix_fe_blk_ctlr with BLK_WORDS=4, NUM_BLK=4: cycle table plus frame sequences.
module tb_cr_prefix_fe_blk_ctlr;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_vbytes;
  logic        in_eot;
  logic [63:0] out_data;
  logic [7:0]  out_vbytes;
  logic        out_valid;
  logic [1:0]  blk_sel;
  logic [3:0]  blk_wr;
  logic        eodb;
  logic        flush_active;
  logic        ovfl;
`ifdef CR_PREFIX_FE_PERF_CTR_EN
  logic [31:0] frm_cnt;
  logic [31:0] flush_cnt;
`endif

  cr_prefix_fe_blk_ctlr #(.DATA_W(64), .BLK_WORDS(4), .NUM_BLK(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_vbytes(in_vbytes), .in_eot(in_eot),
    .out_data(out_data), .out_vbytes(out_vbytes), .out_valid(out_valid),
    .blk_sel(blk_sel), .blk_wr(blk_wr), .eodb(eodb),
    .flush_active(flush_active), .ovfl(ovfl)
`ifdef CR_PREFIX_FE_PERF_CTR_EN
    , .frm_cnt(frm_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // {in_ready, out_valid, eodb, blk_wr, blk_sel, flush_active, ovfl, out_data, out_vbytes}
  function automatic logic [82:0] obs();
    return {in_ready, out_valid, eodb, blk_wr, blk_sel, flush_active, ovfl, out_data, out_vbytes};
  endfunction

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [7:0]  vb;
    logic        eot;
    logic [82:0] exp;
  } vec_t;

  function automatic vec_t row(input logic v, input int d, input int vb, input logic eot,
                               input logic rdy, input logic ov, input logic eo, input logic [3:0] wr,
                               input logic [1:0] sel, input logic fa, input logic of,
                               input int xd, input int xvb);
    vec_t r;
    r.v   = v;
    r.d   = 64'(d);
    r.vb  = 8'(vb);
    r.eot = eot;
    r.exp = {rdy, ov, eo, wr, sel, fa, of, 64'(xd), 8'(xvb)};
    return r;
  endfunction

  int mon_ov, mon_eodb, mon_fa, mon_ovfl, mon_rdy_lo, acc_last_cyc, ovfl_cyc, frame_cyc;
  logic [63:0] mon_last_d;
  logic [3:0]  wr_seen[$];

  // Sends n beats (eot on the last if eot_last), holding each until accepted, and records outputs.
  task automatic run_frame(input int n, input logic eot_last, input logic [63:0] base);
    int sent = 0;
    int drain = 0;
    int cyc = 0;
    mon_ov = 0; mon_eodb = 0; mon_fa = 0; mon_ovfl = 0; mon_rdy_lo = 0;
    acc_last_cyc = -1; ovfl_cyc = -1; mon_last_d = '0;
    wr_seen.delete();
    while (drain < 5 && cyc < 300) begin
      @(posedge clk); #1;
      if (sent < n) begin
        in_valid  = 1'b1;
        in_data   = base + 64'(sent);
        in_vbytes = 8'd8;
        in_eot    = eot_last && (sent == n - 1);
      end else begin
        in_valid = 1'b0;
        in_eot   = 1'b0;
      end
      @(negedge clk);
      if (out_valid) begin mon_ov++; mon_last_d = out_data; end
      if (eodb) mon_eodb++;
      if (flush_active) mon_fa++;
      if (ovfl) begin mon_ovfl++; ovfl_cyc = cyc; end
      if (!in_ready) mon_rdy_lo++;
      if (blk_wr != 4'b0) wr_seen.push_back(blk_wr);
      if (in_valid && in_ready) begin sent++; acc_last_cyc = cyc; end
      if (sent >= n) drain++;
      cyc++;
    end
    frame_cyc = cyc;
    in_valid = 1'b0;
    in_eot   = 1'b0;
    chk("frame_timeout", 128'(cyc < 300), 128'(1));
  endtask

  task automatic chk_wr_seq(input string name, input logic [3:0] e0, input logic [3:0] e1,
                            input logic [3:0] e2, input logic [3:0] e3);
    logic [3:0] exp_q[4];
    exp_q = '{e0, e1, e2, e3};
    chk({name, "_wr_count"}, 128'(wr_seen.size()), 128'(4));
    for (int i = 0; i < 4; i++)
      chk({name, "_wr"}, 128'((i < wr_seen.size()) ? wr_seen[i] : 4'hx), 128'(exp_q[i]));
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Per-cycle table; expectations are the outputs visible in the cycle the row's inputs are driven.
    //                  v  d   vb eot  rdy ov eo wr     sel fa of xd  xvb
    vecs.push_back(row(1, 1,  8, 0,   1,  0, 0, 4'h0, 0,  0, 0, 0,  0));
    vecs.push_back(row(1, 2,  8, 0,   1,  1, 0, 4'h0, 0,  0, 0, 1,  8));
    vecs.push_back(row(1, 3,  8, 0,   1,  1, 0, 4'h0, 0,  0, 0, 2,  8));
    vecs.push_back(row(1, 4,  8, 0,   1,  1, 0, 4'h0, 0,  0, 0, 3,  8));
    vecs.push_back(row(0, 0,  0, 0,   0,  1, 1, 4'h0, 0,  0, 0, 4,  8));
    vecs.push_back(row(1, 5,  8, 0,   1,  0, 0, 4'h1, 1,  0, 0, 4,  8));
    vecs.push_back(row(1, 6,  3, 1,   1,  1, 0, 4'h0, 1,  0, 0, 5,  8));
    vecs.push_back(row(0, 0,  0, 0,   0,  1, 1, 4'h0, 1,  0, 0, 6,  3));
    vecs.push_back(row(0, 0,  0, 0,   1,  0, 0, 4'hE, 0,  0, 0, 6,  3));
    vecs.push_back(row(0, 0,  0, 0,   1,  0, 0, 4'h0, 0,  0, 0, 6,  3));
    vecs.push_back(row(1, 7,  0, 1,   1,  0, 0, 4'h0, 0,  0, 0, 6,  3));
    vecs.push_back(row(0, 0,  0, 0,   0,  1, 1, 4'h0, 0,  0, 0, 7,  0));
    vecs.push_back(row(0, 0,  0, 0,   1,  0, 0, 4'hF, 0,  0, 0, 7,  0));
    vecs.push_back(row(0, 0,  0, 0,   1,  0, 0, 4'h0, 0,  0, 0, 7,  0));
    vecs.push_back(row(1, 8,  8, 0,   1,  0, 0, 4'h0, 0,  0, 0, 7,  0));
    vecs.push_back(row(1, 9,  5, 1,   1,  1, 0, 4'h0, 0,  0, 0, 8,  8));
    vecs.push_back(row(1, 10, 1, 1,   0,  1, 1, 4'h0, 0,  0, 0, 9,  5));
    vecs.push_back(row(1, 10, 1, 1,   1,  0, 0, 4'hF, 0,  0, 0, 9,  5));
    vecs.push_back(row(0, 0,  0, 0,   0,  1, 1, 4'h0, 0,  0, 0, 10, 1));
    vecs.push_back(row(0, 0,  0, 0,   1,  0, 0, 4'hF, 0,  0, 0, 10, 1));
    vecs.push_back(row(0, 0,  0, 0,   1,  0, 0, 4'h0, 0,  0, 0, 10, 1));

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_vbytes = '0; in_eot = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 128'(obs()), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      in_valid  = vecs[i].v;
      in_data   = vecs[i].d;
      in_vbytes = vecs[i].vb;
      in_eot    = vecs[i].eot;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 128'(obs()), 128'(vecs[i].exp));
    end

    // Reset mid-frame while filling block 2
    run_frame(10, 1'b0, 64'h100);
    chk("pre_reset_blk_sel", 128'(blk_sel), 128'(2));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", 128'(obs()), 128'(0));
    @(negedge clk);
    chk("ready_after_reset", 128'({in_ready, blk_sel}), 128'({1'b1, 2'd0}));
    run_frame(1, 1'b1, 64'h200);
    chk("post_reset_wr_count", 128'(wr_seen.size()), 128'(1));
    chk("post_reset_wr", 128'((wr_seen.size() > 0) ? wr_seen[0] : 4'hx), 128'(4'hF));
    chk("post_reset_data", 128'(mon_last_d), 128'(64'h200));

    // Exactly NUM_BLK*BLK_WORDS beats with eot on the last: normal close, no flush
    run_frame(16, 1'b1, 64'h300);
    chk_wr_seq("full", 4'h1, 4'h2, 4'h4, 4'h8);
    chk("full_ov", 128'(mon_ov), 128'(16));
    chk("full_eodb", 128'(mon_eodb), 128'(4));
    chk("full_flush", 128'({mon_fa, mon_ovfl}), 128'(0));
    chk("full_rdy_lo", 128'(mon_rdy_lo), 128'(4));
    chk("full_last_data", 128'(mon_last_d), 128'(64'h30F));

    // Overflow: 20 beats, last 4 flushed
    run_frame(20, 1'b1, 64'h400);
    chk_wr_seq("ovfl", 4'h1, 4'h2, 4'h4, 4'h8);
    chk("ovfl_ov", 128'(mon_ov), 128'(16));
    chk("ovfl_eodb", 128'(mon_eodb), 128'(4));
    chk("ovfl_fa_cycles", 128'(mon_fa), 128'(4));
    chk("ovfl_pulses", 128'(mon_ovfl), 128'(1));
    chk("ovfl_timing", 128'(ovfl_cyc), 128'(acc_last_cyc + 1));
    chk("ovfl_last_data", 128'(mon_last_d), 128'(64'h40F));
`ifdef CR_PREFIX_FE_PERF_CTR_EN
    chk("frm_cnt", 128'(frm_cnt), 128'(2));
    chk("flush_cnt", 128'(flush_cnt), 128'(1));
`endif

    run_frame(1, 1'b1, 64'h500);
    chk("after_ovfl_wr_count", 128'(wr_seen.size()), 128'(1));
    chk("after_ovfl_wr", 128'((wr_seen.size() > 0) ? wr_seen[0] : 4'hx), 128'(4'hF));
    chk("after_ovfl_flags", 128'({mon_fa, mon_ovfl}), 128'(0));

`ifdef CR_PREFIX_FE_PERF_CTR_EN
    force dut.frm_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.frm_cnt_q;
    run_frame(1, 1'b1, 64'h600);
    chk("frm_cnt_sat", 128'(frm_cnt), 128'(32'hFFFF_FFFF));
    chk("flush_cnt_hold", 128'(flush_cnt), 128'(1));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
